branch_predictor_gshare: RTL and testbench

Parametrised dynamic branch predictor that drops into `branch_controller` in place of the fixed-policy predictors, using the identical request/feedback port set. It holds a table of N-bit saturating counters indexed by PC bits. The PC bits are optionally XOR-hashed with a global history register (gshare mode) or used directly (bimodal mode). It also exports saturating branch and mispredict counters for performance measurement.

---
 rtl/branch_predictor_gshare_pkg.sv | 12 +
 rtl/branch_predictor_gshare_sat_counter.sv | 14 +
 rtl/branch_predictor_gshare.sv | 57 +++++
 tb/tb_branch_predictor_gshare.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_gshare_pkg.sv
// branch_predictor_gshare_pkg: shared branch types, predictor defaults and counter init helper
package branch_predictor_gshare_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int BP_INDEX_BITS = 8;
  localparam int BP_COUNTER_BITS = 2;
  localparam int BP_HISTORY_BITS = 8;
  typedef enum logic {NOT_TAKEN = 1'b0, TAKEN = 1'b1} BranchOutcome;
  // weakly not-taken: MSB clear, all lower bits set (0 for a 1-bit counter)
  function automatic logic [3:0] bp_counter_init(input int bits);
    return 4'((1 << (bits - 1)) - 1);
  endfunction
endpackage

// File: rtl/branch_predictor_gshare_sat_counter.sv
// bp_sat_counter_next: next value of one saturating up/down counter
module bp_sat_counter_next
  import branch_predictor_gshare_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] value,
  input  BranchOutcome     outcome,
  output logic [WIDTH-1:0] value_next
);
  always_comb
    value_next = outcome == TAKEN ? (&value ? value : value + WIDTH'(1))
                                  : (|value ? value - WIDTH'(1) : value);
endmodule

// File: rtl/branch_predictor_gshare.sv
// branch_predictor_gshare: gshare/bimodal table of saturating counters with
// committed global history and saturating branch/mispredict statistics
module branch_predictor_gshare
  import branch_predictor_gshare_pkg::*;
#(
  parameter int INDEX_BITS   = BP_INDEX_BITS,
  parameter int COUNTER_BITS = BP_COUNTER_BITS,
  parameter int HISTORY_BITS = BP_HISTORY_BITS,
  parameter bit USE_HISTORY  = 1'b1,
  parameter int STAT_BITS    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req_valid,
  input  logic [ADDR_WIDTH-1:0] i_req_pc,
  input  logic [ADDR_WIDTH-1:0] i_req_target,
  output BranchOutcome          o_req_prediction,
  input  logic                  i_fb_valid,
  input  logic [ADDR_WIDTH-1:0] i_fb_pc,
  input  BranchOutcome          i_fb_prediction,
  input  BranchOutcome          i_fb_outcome,
  output logic [STAT_BITS-1:0]  o_stat_branches,
  output logic [STAT_BITS-1:0]  o_stat_mispredicts
);
  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam logic [COUNTER_BITS-1:0] INIT = COUNTER_BITS'(bp_counter_init(COUNTER_BITS));
  logic [COUNTER_BITS-1:0] pht [ENTRIES];
  logic [HISTORY_BITS-1:0] ghr;
  logic [INDEX_BITS-1:0]   hist_mask, req_idx, fb_idx;
  logic [COUNTER_BITS-1:0] fb_next;
  logic                    unused;
  assign unused = ^{i_req_valid, i_req_target, i_req_pc, i_fb_pc};
  assign hist_mask = USE_HISTORY ? INDEX_BITS'(ghr) : '0;
  assign req_idx = i_req_pc[INDEX_BITS+1:2] ^ hist_mask;
  assign fb_idx = i_fb_pc[INDEX_BITS+1:2] ^ hist_mask;
  assign o_req_prediction = BranchOutcome'(pht[req_idx][COUNTER_BITS-1]);
  bp_sat_counter_next #(.WIDTH(COUNTER_BITS)) u_next (
    .value(pht[fb_idx]),
    .outcome(i_fb_outcome),
    .value_next(fb_next)
  );
  // truncating the concatenation keeps the newest HISTORY_BITS outcomes, also for width 1
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) pht[i] <= INIT;
      ghr <= '0;
      o_stat_branches <= '0;
      o_stat_mispredicts <= '0;
    end else if (i_fb_valid) begin
      pht[fb_idx] <= fb_next;
      ghr <= HISTORY_BITS'({ghr, i_fb_outcome == TAKEN});
      o_stat_branches <= &o_stat_branches ? o_stat_branches : o_stat_branches + STAT_BITS'(1);
      if (i_fb_prediction != i_fb_outcome)
        o_stat_mispredicts <= &o_stat_mispredicts ? o_stat_mispredicts
                                                  : o_stat_mispredicts + STAT_BITS'(1);
    end
endmodule

// File: tb/tb_branch_predictor_gshare.sv
// tb_branch_predictor_gshare: directed checks of a gshare instance (defaults)
// and a bimodal instance with 4-bit statistics, against a behavioural model
module tb_branch_predictor_gshare;
  import branch_predictor_gshare_pkg::*;
  localparam logic T = 1'b1, N = 1'b0;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, fb_valid = 1'b0;
  logic [31:0] req_pc = 32'h100, req_target = 32'h0, fb_pc = 32'h0;
  BranchOutcome fb_pred = NOT_TAKEN, fb_out = NOT_TAKEN, pred_g, pred_b;
  logic [31:0] br_g, mp_g;
  logic [3:0] br_b, mp_b;
  int checks = 0, passed = 0, fails = 0;
  int m_g [256], m_b [256];
  logic [7:0] m_ghr;
  longint m_br_g, m_mp_g;
  int m_br_b, m_mp_b;
  logic [1:0] exp_q [$];
  logic s_pred_g, s_pred_b;
  logic [3:0] s_br_b, s_mp_b;
  logic p;

  branch_predictor_gshare dut_g (
    .clk(clk), .rst_n(rst_n), .i_req_valid(req_valid), .i_req_pc(req_pc),
    .i_req_target(req_target), .o_req_prediction(pred_g), .i_fb_valid(fb_valid),
    .i_fb_pc(fb_pc), .i_fb_prediction(fb_pred), .i_fb_outcome(fb_out),
    .o_stat_branches(br_g), .o_stat_mispredicts(mp_g)
  );
  branch_predictor_gshare #(.USE_HISTORY(1'b0), .STAT_BITS(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .i_req_valid(req_valid), .i_req_pc(req_pc),
    .i_req_target(req_target), .o_req_prediction(pred_b), .i_fb_valid(fb_valid),
    .i_fb_pc(fb_pc), .i_fb_prediction(fb_pred), .i_fb_outcome(fb_out),
    .o_stat_branches(br_b), .o_stat_mispredicts(mp_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 256; i++) begin
      m_g[i] = 1;
      m_b[i] = 1;
    end
    m_ghr = 8'h0;
    m_br_g = 0; m_mp_g = 0; m_br_b = 0; m_mp_b = 0;
  endtask

  function automatic logic m_pred_g(input logic [31:0] pc);
    return m_g[pc[9:2] ^ m_ghr] >= 2;
  endfunction

  function automatic logic m_pred_b(input logic [31:0] pc);
    return m_b[pc[9:2]] >= 2;
  endfunction

  task automatic m_update(input logic [31:0] pc, input logic fp, input logic fo);
    int ig, ib;
    ig = int'(pc[9:2] ^ m_ghr);
    ib = int'(pc[9:2]);
    m_g[ig] = fo ? (m_g[ig] < 3 ? m_g[ig] + 1 : 3) : (m_g[ig] > 0 ? m_g[ig] - 1 : 0);
    m_b[ib] = fo ? (m_b[ib] < 3 ? m_b[ib] + 1 : 3) : (m_b[ib] > 0 ? m_b[ib] - 1 : 0);
    m_ghr = {m_ghr[6:0], fo};
    m_br_g++;
    if (m_br_b < 15) m_br_b++;
    if (fp != fo) begin
      m_mp_g++;
      if (m_mp_b < 15) m_mp_b++;
    end
  endtask

  // one cycle: drive at negedge, compare outputs mid-cycle, advance model at posedge
  task automatic step(input logic [31:0] rpc, input logic fv, input logic [31:0] fpc,
                      input logic fp, input logic fo);
    logic [1:0] e;
    @(negedge clk);
    req_valid = 1'b1;
    req_pc = rpc;
    fb_valid = fv;
    fb_pc = fpc;
    fb_pred = BranchOutcome'(fp);
    fb_out = BranchOutcome'(fo);
    exp_q.push_back({m_pred_g(rpc), m_pred_b(rpc)});
    #2;
    e = exp_q.pop_front();
    chk("pred_g", pred_g, e[1]);
    chk("pred_b", pred_b, e[0]);
    chk("br_g", br_g, 32'(m_br_g));
    chk("mp_g", mp_g, 32'(m_mp_g));
    chk("br_b", br_b, m_br_b);
    chk("mp_b", mp_b, m_mp_b);
    s_pred_g = pred_g;
    s_pred_b = pred_b;
    s_br_b = br_b;
    s_mp_b = mp_b;
    @(posedge clk);
    if (fv) m_update(fpc, fp, fo);
  endtask

  initial begin
    m_reset();
    #3;
    chk("rst_pred_g", pred_g, 0);
    chk("rst_pred_b", pred_b, 0);
    chk("rst_br_g", br_g, 0);
    chk("rst_mp_g", mp_g, 0);
    chk("rst_br_b", br_b, 0);
    chk("rst_mp_b", mp_b, 0);
    @(negedge clk);
    rst_n = 1'b1;
    // bimodal: T,T,T,T then N,N at pc 0x100
    step(32'h100, 1, 32'h100, N, T);
    step(32'h100, 1, 32'h100, T, T);
    step(32'h100, 1, 32'h100, T, T);
    chk("bim_2T", s_pred_b, 1);
    step(32'h100, 1, 32'h100, T, T);
    step(32'h100, 1, 32'h100, T, N);
    step(32'h100, 1, 32'h100, T, N);
    chk("bim_sat_hi", s_pred_b, 1);
    step(32'h100, 0, 32'h0, N, N);
    chk("bim_2NT", s_pred_b, 0);
    // gshare: alternating outcomes at pc 0x40, request one cycle before resolution
    for (int i = 0; i < 20; i++) begin
      step(32'h40, 0, 32'h0, N, N);
      p = s_pred_g;
      step(32'h40, 1, 32'h40, p, (i % 2) == 0);
      if (i >= 14) chk("gs_alt", p, (i % 2) == 0);
    end
    // same-cycle request and feedback, no bypass
    step(32'h200, 1, 32'h200, N, T);
    chk("same_cyc", s_pred_b, 0);
    step(32'h200, 0, 32'h0, N, N);
    chk("same_next", s_pred_b, 1);
    // statistics saturation on the 4-bit instance
    repeat (20) step(32'h300, 1, 32'h300, T, N);
    step(32'h300, 0, 32'h0, N, N);
    chk("sat_br", s_br_b, 4'hF);
    chk("sat_mp", s_mp_b, 4'hF);
    // asynchronous reset mid-cycle after five taken feedbacks
    repeat (5) step(32'h100, 1, 32'h100, T, T);
    @(negedge clk);
    fb_valid = 1'b0;
    req_pc = 32'h100;
    #1 rst_n = 1'b0;
    m_reset();
    #1;
    chk("arst_pred_g", pred_g, 0);
    chk("arst_pred_b", pred_b, 0);
    chk("arst_br_g", br_g, 0);
    chk("arst_mp_g", mp_g, 0);
    chk("arst_br_b", br_b, 0);
    chk("arst_mp_b", mp_b, 0);
    req_pc = 32'h200;
    #1 chk("arst_pc200_b", pred_b, 0);
    @(negedge clk);
    rst_n = 1'b1;
    // first feedback after reset uses ghr=0 and initial counters
    step(32'h40, 1, 32'h40, N, T);
    step(32'h44, 0, 32'h0, N, N);
    chk("post_rst_44", s_pred_g, 1);
    step(32'h40, 0, 32'h0, N, N);
    chk("post_rst_40", s_pred_g, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
